// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer, centre-of-bit
// sampling, glitch rejection on the start bit, and stop-bit framing check with
// break handling. Single clock domain, synchronous active-high reset.
//
// The bit timer counts cycles since the last state entry or sample point.
// The start bit is confirmed HALF_BIT cycles after the falling edge. Each
// later sample is one full bit period after the previous one, so every
// sample lands near the centre of its bit. CLKS_PER_BIT must be at least 2.

module uart_rx #(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] uart_rx_byte,
    output logic       uart_rx_irq,
    output logic       frame_err_o
);

    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    // The counter holds (cycles elapsed - 1) just before a sample edge.
    // These are the counter values at which the start and data/stop samples fire.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    // Synchronizer stages; rxs is the line as seen by the rest of the receiver.
    logic             sync1_q;
    logic             sync2_q;
    logic             rxs;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q,  byte_d;
    logic             irq_q,   irq_d;
    logic             ferr_q,  ferr_d;

    assign rxs = sync2_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values and the stages do not collapse into one.
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    // State, timer, data path and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            irq_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            irq_q   <= irq_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: frame sequencing, bit sampling and output pulses.
    always_comb begin
        // NOTE: every signal driven here gets a default first. Any path that
        // left a signal unassigned would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        irq_d   = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        // Low pulse shorter than half a bit: a glitch, not a start bit.
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_d  = shift_q;
                        irq_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                // Wait out a held-low line so a break is not read as a new start bit.
                cnt_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign uart_rx_byte = byte_q;
    assign uart_rx_irq  = irq_q;
    assign frame_err_o  = ferr_q;

    // A frame ends either good or framed-bad, never both at once.
    a_irq_ferr_exclusive : assert property (
        @(posedge clk_i) disable iff (reset_i) !(uart_rx_irq && frame_err_o)
    );

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100000000, clock frequency in Hz.
- REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bits/s.
- REQ-003 SHALL have derived constant CLKS_PER_BIT = SYS_CLK_FREQ/BAUD_RATE (integer division), with H = CLKS_PER_BIT/2 (integer).
- REQ-004 SHALL have port clk_i  input  1  system clock; one clock domain, all state on rising edge.
- REQ-005 SHALL have port reset_i  input  1  reset, synchronous and active-high.
- REQ-006 SHALL have port rx_i  input  1  asynchronous serial line; idle high; 8N1 framing.
- REQ-007 SHALL have port uart_rx_byte  output  8  last correctly framed byte, held until the next one.
- REQ-008 SHALL have port uart_rx_irq  output  1  one-cycle pulse marking a new valid uart_rx_byte.
- REQ-009 SHALL have port frame_err_o  output  1  one-cycle pulse on a stop-bit error.

Function
- REQ-010 SHALL pass rx_i through a 2-flop synchronizer; "rxs" below means its output, 2 cycles behind rx_i.
- REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK, using one bit-timing counter of width >= clog2(CLKS_PER_BIT)+1 and a 3-bit bit index.
- REQ-012 IDLE: on the first cycle with rxs=0 (call it cycle 0), SHALL go to START with the counter cleared; otherwise SHALL stay in IDLE.
- REQ-013 START: at cycle H, SHALL resample rxs; if 0, go to DATA with the counter cleared and the bit index at 0; if 1, treat it as a glitch and return to IDLE with no output activity.
- REQ-014 DATA: SHALL sample data bit k (k=0..7) at cycle H+(k+1)*CLKS_PER_BIT into the shift register, LSB first.
- REQ-015 After bit 7 is sampled, SHALL go to STOP.
- REQ-016 STOP: SHALL sample rxs at cycle H+9*CLKS_PER_BIT.
- REQ-017 If the stop sample is 1, SHALL load uart_rx_byte with the shift register, pulse uart_rx_irq for exactly one cycle (the cycle after the sample), and return to IDLE.
- REQ-018 If the stop sample is 0, SHALL pulse frame_err_o for one cycle, leave uart_rx_byte unchanged, keep uart_rx_irq low, and go to BREAK.
- REQ-019 BREAK: SHALL stay until rxs=1, then go to IDLE; a held-low line (break) SHALL NOT retrigger reception.
- REQ-020 Back-to-back frames: a start edge seen in IDLE on the cycle right after the return from STOP SHALL be accepted; no minimum idle gap beyond the stop bit sample point.
- REQ-021 uart_rx_irq and frame_err_o SHALL never be high in the same cycle; each is high for at most 1 cycle per frame.
- REQ-022 Latency: the uart_rx_irq rising edge SHALL occur H+9*CLKS_PER_BIT+1 cycles after cycle 0, i.e. H+9*CLKS_PER_BIT+3 cycles after the rx_i falling edge.
- REQ-023 uart_rx_byte SHALL change only in the cycle where uart_rx_irq is asserted.
- REQ-024 The counter SHALL NOT wrap within a frame; it SHALL clear on each sample point and on every state entry.

Reset
- REQ-025 While reset_i=1 at a clock edge: state=IDLE, counter=0, bit index=0, shift register=0, uart_rx_byte=8'h00, uart_rx_irq=0, frame_err_o=0, both synchronizer flops=1.
- REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse on any output.
- REQ-027 After reset release, a line that is already low SHALL be treated as a start edge after the 2-cycle synchronizer delay.

Verification (SYS_CLK_FREQ=1600, BAUD_RATE=100 -> CLKS_PER_BIT=16, H=8)
- REQ-028 Send 8'h2d (0,1,0,1,1,0,1,0,0 then stop 1), LSB first -> uart_rx_byte=8'h2d; single-cycle uart_rx_irq 155 cycles after the rx_i fall; frame_err_o stays 0.
- REQ-029 Send 8'h70 then 8'h5f back-to-back with a 1-bit stop only -> two uart_rx_irq pulses, bytes 8'h70 then 8'h5f, exactly 160 cycles apart.
- REQ-030 Drive rx_i low for 4 cycles, then high -> START aborts at H; no uart_rx_irq, no frame_err_o; state returns to IDLE.
- REQ-031 Send 8'hA5 with the stop bit forced low and the line held low for 50 more cycles, then 8'h33 after the line rises -> frame_err_o pulses once, uart_rx_byte stays at its previous value; then 8'h33 is received with one uart_rx_irq pulse.
- REQ-032 Assert reset_i at bit 4 of a frame for 1 cycle, then release with the line high -> no pulse on any output; uart_rx_byte=8'h00; the next 8'hFF frame is received correctly.
- REQ-033 Send 8'h00 and 8'hFF with rx_i edges skewed by +/-3 cycles per bit -> both bytes are received correctly.
